mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/mem_access_stage_load_align.sv | 32 +++
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access pipeline stage.
//   state_e        - stage FSM states (IDLE, WAIT)
//   F3_*           - Funct3 access size/sign codes
//   size_e         - decoded access size
//   access_size()  - Funct3 -> size (store and load code maps differ)
//   is_aligned()   - natural alignment check on the low address bits
//   byte_enable()  - lane mask for an access of a given size/offset
package mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Unsigned load codes only exist for loads; a store with 100/101 is a word.
  function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
    size_e sz;
    sz = SZ_WORD;
    unique case (f3)
      F3_B:    sz = SZ_BYTE;
      F3_H:    sz = SZ_HALF;
      F3_BU:   sz = is_store ? SZ_WORD : SZ_BYTE;
      F3_HU:   sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] lo);
    logic ok;
    unique case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] lo);
    logic [3:0] be;
    unique case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load-data extractor.
//   rdata_i  - raw word returned by data memory
//   off_i    - byte offset of the access within the word (addr[1:0])
//   funct3_i - load size/sign code
//   data_o   - selected byte/halfword, sign- or zero-extended; words pass through
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    unique case (funct3_i)
      F3_B:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory-access stage with a req/ack data-memory port.
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   ValidIn..immIn    - upstream instruction fields (ignored while in WAIT,
//                       except FlushIn, which marks the pending access killed)
//   dm_*              - data-memory request port; request fields are held
//                       stable from capture until dm_ack is sampled high
//   ValidOut..immOut  - registered writeback-side fields
//   MisalignOut       - one-cycle flag for a misaligned load/store
//   StallOut          - combinational hold request to the upstream stage
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidIn,
  input  logic                  FlushIn,
  input  logic [DATA_W-1:0]     ALUresultIn,
  input  logic [DATA_W-1:0]     StoreDataIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic [2:0]            Funct3In,
  input  logic                  RegWrtEnIn,
  input  logic [2:0]            RegWrtSrcIn,
  input  logic [4:0]            RegDstIn,
  input  logic [DM_ADDRESS-1:0] PCin,
  input  logic [DATA_W-1:0]     immIn,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  output logic [3:0]            dm_be,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic                  ValidOut,
  output logic [DATA_W-1:0]     MemRdDataOut,
  output logic [DATA_W-1:0]     MemALUresultOut,
  output logic                  RegWrtEnOut,
  output logic [2:0]            RegWrtSrcOut,
  output logic [4:0]            RegDstOut,
  output logic [DM_ADDRESS-1:0] PCOut,
  output logic [DATA_W-1:0]     immOut,
  output logic                  MisalignOut,
  output logic                  StallOut
);

  state_e state_q, state_d;

  // Decode of the instruction presented in IDLE.
  logic  is_mem, is_store, accept, aligned, start_mem, misalign;
  size_e in_size;

  assign is_mem    = MemReadIn | MemWriteIn;
  assign is_store  = MemWriteIn;   // read+write together behaves as a store
  assign in_size   = access_size(Funct3In, is_store);
  assign aligned   = is_aligned(in_size, ALUresultIn[1:0]);
  assign accept    = (state_q == IDLE) & ValidIn & ~FlushIn;
  assign start_mem = accept & is_mem & aligned;
  assign misalign  = accept & is_mem & ~aligned;

  // Store data replicated across every lane of its size; dm_be picks the lane.
  logic [DATA_W-1:0] store_lanes;
  always_comb begin
    unique case (in_size)
      SZ_BYTE: store_lanes = {(DATA_W/8){StoreDataIn[7:0]}};
      SZ_HALF: store_lanes = {(DATA_W/16){StoreDataIn[15:0]}};
      default: store_lanes = StoreDataIn;
    endcase
  end

  // Access captured at launch and held for the whole WAIT.
  logic                  cap_we_q;
  logic [DM_ADDRESS-1:0] cap_addr_q;
  logic [DATA_W-1:0]     cap_wdata_q;
  logic [3:0]            cap_be_q;
  logic [2:0]            cap_f3_q;
  logic [1:0]            cap_off_q;
  logic                  cap_wen_q;
  logic                  kill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
      cap_f3_q    <= '0;
      cap_off_q   <= '0;
      cap_wen_q   <= 1'b0;
      kill_q      <= 1'b0;
    end else if (start_mem) begin
      cap_we_q    <= is_store;
      cap_addr_q  <= {ALUresultIn[DM_ADDRESS-1:2], 2'b00};
      cap_wdata_q <= store_lanes;
      cap_be_q    <= byte_enable(in_size, ALUresultIn[1:0]);
      cap_f3_q    <= Funct3In;
      cap_off_q   <= ALUresultIn[1:0];
      cap_wen_q   <= RegWrtEnIn;
      kill_q      <= 1'b0;
    end else if (state_q == WAIT && FlushIn) begin
      kill_q <= 1'b1;
    end
  end

  logic [DATA_W-1:0] load_data;

  load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .rdata_i  (dm_rdata),
    .off_i    (cap_off_q),
    .funct3_i (cap_f3_q),
    .data_o   (load_data)
  );

  // Writeback-side output registers.
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic                  wen_q, wen_d;
  logic [2:0]            src_q, src_d;
  logic [4:0]            dst_q, dst_d;
  logic [DM_ADDRESS-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic                  misal_q, misal_d;
  logic                  kill_now;

  assign kill_now = kill_q | FlushIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      wen_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wen_q   <= wen_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      misal_q <= misal_d;
    end
  end

  // The pass-through fields are loaded in IDLE on every edge, including the
  // launch edge of a memory op; they then simply hold through WAIT, so the
  // completion edge only has to supply valid, write-enable and load data.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    wen_d   = 1'b0;
    misal_d = 1'b0;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    src_d   = src_q;
    dst_d   = dst_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        alu_d   = ALUresultIn;
        src_d   = RegWrtSrcIn;
        dst_d   = RegDstIn;
        pc_d    = PCin;
        imm_d   = immIn;
        valid_d = accept & ~start_mem;
        wen_d   = accept & ~is_mem & RegWrtEnIn;
        misal_d = misalign;
        if (start_mem) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dm_ack) begin
          state_d = IDLE;
          valid_d = ~kill_now;
          wen_d   = cap_wen_q & ~kill_now;
          rdata_d = cap_we_q ? '0 : load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dm_req   = (state_q == WAIT);
  assign dm_we    = dm_req & cap_we_q;
  assign dm_be    = dm_req ? cap_be_q : '0;
  assign dm_addr  = cap_addr_q;
  assign dm_wdata = cap_wdata_q;

  // rst gates the combinational path so a held ValidIn cannot stall during reset.
  assign StallOut = ~rst & (start_mem | ((state_q == WAIT) & ~dm_ack));

  assign ValidOut        = valid_q;
  assign MemRdDataOut    = rdata_q;
  assign MemALUresultOut = alu_q;
  assign RegWrtEnOut     = wen_q;
  assign RegWrtSrcOut    = src_q;
  assign RegDstOut       = dst_q;
  assign PCOut           = pc_q;
  assign immOut          = imm_q;
  assign MisalignOut     = misal_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage. A byte-level
// reference memory predicts every writeback result and memory request; a
// responder plays the data memory and a monitor checks ValidOut beats.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidIn, FlushIn, MemReadIn, MemWriteIn, RegWrtEnIn;
  logic [31:0] ALUresultIn, StoreDataIn, immIn;
  logic [2:0]  Funct3In, RegWrtSrcIn;
  logic [4:0]  RegDstIn;
  logic [8:0]  PCin;
  logic        dm_req, dm_we, dm_ack;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        ValidOut, RegWrtEnOut, MisalignOut, StallOut;
  logic [31:0] MemRdDataOut, MemALUresultOut, immOut;
  logic [2:0]  RegWrtSrcOut;
  logic [4:0]  RegDstOut;
  logic [8:0]  PCOut;

  mem_access_stage #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ValidIn(ValidIn), .FlushIn(FlushIn),
    .ALUresultIn(ALUresultIn), .StoreDataIn(StoreDataIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .Funct3In(Funct3In),
    .RegWrtEnIn(RegWrtEnIn), .RegWrtSrcIn(RegWrtSrcIn), .RegDstIn(RegDstIn),
    .PCin(PCin), .immIn(immIn),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ValidOut(ValidOut), .MemRdDataOut(MemRdDataOut),
    .MemALUresultOut(MemALUresultOut), .RegWrtEnOut(RegWrtEnOut),
    .RegWrtSrcOut(RegWrtSrcOut), .RegDstOut(RegDstOut), .PCOut(PCOut),
    .immOut(immOut), .MisalignOut(MisalignOut), .StallOut(StallOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, sd, imm;
    logic [8:0]  pc;
    logic [2:0]  f3, src;
    logic [4:0]  dst;
    logic        rd, wr, wen, flush_idle, flush_wait;
  } ins_t;

  typedef struct {
    logic [31:0] rd, alu, imm;
    logic [8:0]  pc;
    logic [4:0]  dst;
    logic [2:0]  src;
    logic        wen, mis;
  } exp_t;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t exp_req[$];

  int errors = 0;
  int checks = 0;

  logic [7:0]  mbytes[512];   // reference memory, byte granular
  logic [31:0] rmem[128];     // responder memory, word granular

  int   force_delay = -1;
  bit   resp_en = 1'b1;
  bit   busy = 1'b0;
  int   wait_left = 0;
  int   reqs_seen = 0;
  int   req_cycles = 0;
  logic        last_we;
  logic [8:0]  last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_word(input int unsigned a, input logic [31:0] w);
    rmem[a >> 2] = w;
    for (int k = 0; k < 4; k++) mbytes[(a & ~32'd3) + k] = w[8*k +: 8];
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3, input bit st);
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  // Reference model: predicts request and writeback beat for one instruction.
  task automatic predict(input ins_t i);
    bit          mem, st;
    int unsigned a, n;
    logic [31:0] v;
    exp_t        e;
    req_t        r;
    mem = i.rd | i.wr;
    st  = i.wr;
    a   = i.alu & 32'h1FF;
    n   = nbytes(i.f3, st);
    if (i.flush_idle) return;
    e.alu = i.alu; e.imm = i.imm; e.pc = i.pc; e.dst = i.dst; e.src = i.src;
    e.rd = 32'd0; e.wen = i.wen; e.mis = 1'b0;
    if (!mem) begin
      exp_q.push_back(e);
    end else if ((a % n) != 0) begin
      e.wen = 1'b0; e.mis = 1'b1;
      exp_q.push_back(e);
    end else begin
      r.we = st; r.addr = 9'(a & ~32'd3);
      r.be = 4'(((32'd1 << n) - 1) << (a % 4));
      if (n == 1)      r.wdata = (i.sd & 32'hFF) * 32'h0101_0101;
      else if (n == 2) r.wdata = (i.sd & 32'hFFFF) * 32'h0001_0001;
      else             r.wdata = i.sd;
      exp_req.push_back(r);
      if (st) begin
        for (int k = 0; k < int'(n); k++) mbytes[a + k] = i.sd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < int'(n); k++) v = v | (32'(mbytes[a + k]) << (8 * k));
        if ((i.f3 == 3'd0 || i.f3 == 3'd1) && n < 4 && v[8*n-1])
          v = v | ~((32'd1 << (8 * n)) - 1);
        e.rd = v;
      end
      if (!i.flush_wait) exp_q.push_back(e);
    end
  endtask

  // Presents one instruction and holds it while StallOut is high.
  task automatic issue(input ins_t i, output int stalls);
    predict(i);
    ValidIn = 1'b1; FlushIn = i.flush_idle;
    ALUresultIn = i.alu; StoreDataIn = i.sd; immIn = i.imm; PCin = i.pc;
    Funct3In = i.f3; RegWrtSrcIn = i.src; RegDstIn = i.dst;
    MemReadIn = i.rd; MemWriteIn = i.wr; RegWrtEnIn = i.wen;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!StallOut) break;
      stalls++;
      if (stalls > 50) begin
        checks++; errors++;
        $display("FAIL stall_timeout: got %0d stall cycles expected at most 50", stalls);
        break;
      end
      @(posedge clk); #1;
      FlushIn = i.flush_wait && (stalls == 1);
    end
    @(posedge clk); #1;
    ValidIn = 1'b0; FlushIn = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0;
  endtask

  function automatic ins_t make_ins(input logic [31:0] alu, input logic [31:0] sd,
                                    input logic [2:0] f3, input logic rd, input logic wr,
                                    input logic wen, input logic [4:0] dst);
    ins_t i;
    i.alu = alu; i.sd = sd; i.f3 = f3; i.rd = rd; i.wr = wr; i.wen = wen; i.dst = dst;
    i.imm = $urandom; i.pc = 9'($urandom); i.src = 3'($urandom);
    i.flush_idle = 1'b0; i.flush_wait = 1'b0;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t        i;
    int unsigned k;
    k = $urandom_range(0, 9);
    i = make_ins($urandom, $urandom, 3'($urandom), 1'b0, 1'b0, 1'($urandom), 5'($urandom));
    i.rd = (k >= 3 && k <= 5) || k == 9;
    i.wr = k >= 6;
    if ($urandom_range(0, 1) == 0) i.alu[1:0] = 2'b00;
    i.flush_idle = ($urandom_range(0, 9) == 0);
    i.flush_wait = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  // Monitor: every ValidOut beat must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ValidOut) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got ValidOut=1 expected no beat (alu=0x%0h)", MemALUresultOut);
        end else begin
          e = exp_q.pop_front();
          check("wb_rdata", MemRdDataOut, e.rd);
          check("wb_alu", MemALUresultOut, e.alu);
          check("wb_wen", 32'(RegWrtEnOut), 32'(e.wen));
          check("wb_misalign", 32'(MisalignOut), 32'(e.mis));
          check("wb_dst", 32'(RegDstOut), 32'(e.dst));
          check("wb_src", 32'(RegWrtSrcOut), 32'(e.src));
          check("wb_pc", 32'(PCOut), 32'(e.pc));
          check("wb_imm", immOut, e.imm);
        end
      end
    end
  end

  // Data-memory responder.
  initial begin
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (dm_ack) dm_ack = 1'b0;
        if (dm_req) begin
          if (!busy) begin
            busy = 1'b1; reqs_seen++; req_cycles = 0;
            wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
            last_we = dm_we; last_addr = dm_addr; last_be = dm_be; last_wdata = dm_wdata;
            if (exp_req.size() == 0) begin
              checks++; errors++;
              $display("FAIL req_unexpected: got dm_req addr=0x%0h expected no request", dm_addr);
            end else begin
              r = exp_req.pop_front();
              check("req_we", 32'(dm_we), 32'(r.we));
              check("req_addr", 32'(dm_addr), 32'(r.addr));
              if (r.we) begin
                check("req_be", 32'(dm_be), 32'(r.be));
                check("req_wdata", dm_wdata, r.wdata);
              end
            end
          end else begin
            check("req_stable", {dm_we, dm_addr, dm_be, 18'd0},
                                {last_we, last_addr, last_be, 18'd0});
            check("req_wdata_stable", dm_wdata, last_wdata);
          end
          req_cycles++;
          if (wait_left == 0) begin
            if (dm_we)
              for (int k = 0; k < 4; k++)
                if (dm_be[k]) rmem[dm_addr[8:2]][8*k +: 8] = dm_wdata[8*k +: 8];
            dm_rdata = rmem[dm_addr[8:2]];
            dm_ack = 1'b1;
            busy = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  initial begin
    int   st, r0;
    ins_t i;
    for (int w = 0; w < 128; w++) set_word(w * 4, $urandom);
    dm_ack = 1'b0; dm_rdata = '0;
    FlushIn = 1'b0; MemWriteIn = 1'b0; RegWrtEnIn = 1'b1;
    StoreDataIn = '0; immIn = '0; PCin = '0; RegWrtSrcIn = '0; RegDstIn = '0;
    // Reset with a launchable load held on the inputs.
    rst = 1'b1; ValidIn = 1'b1; MemReadIn = 1'b1; ALUresultIn = 32'h40; Funct3In = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ValidOut), 32'd0);
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_stall", 32'(StallOut), 32'd0);
    check("rst_we_be", {27'd0, dm_we, dm_be}, 32'd0);
    check("rst_wen_mis", {30'd0, RegWrtEnOut, MisalignOut}, 32'd0);
    check("rst_rdata", MemRdDataOut, 32'd0);
    ValidIn = 1'b0; MemReadIn = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory op.
    i = make_ins(32'h55, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    issue(i, st);
    check("alu_stall", st, 0);

    // LB at 0x103, three wait cycles.
    set_word(32'h100, 32'h80FF_FF7F);
    force_delay = 3; r0 = reqs_seen;
    i = make_ins(32'h103, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd3);
    issue(i, st);
    check("lb_stall_cycles", st, 4);
    check("lb_req_cycles", req_cycles, 4);
    check("lb_req_count", reqs_seen, r0 + 1);
    check("lb_addr", 32'(last_addr), 32'h100);
    @(negedge clk);
    check("lb_valid", 32'(ValidOut), 32'd1);
    check("lb_data", MemRdDataOut, 32'hFFFF_FF80);
    @(posedge clk); #1;

    // SH at 0x0A2.
    force_delay = 0;
    i = make_ins(32'h0A2, 32'h1234_ABCD, 3'd1, 1'b0, 1'b1, 1'b0, 5'd9);
    issue(i, st);
    check("sh_be", 32'(last_be), 32'b1100);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check("sh_we", 32'(last_we), 32'd1);

    // Misaligned LW at 0x006.
    r0 = reqs_seen;
    i = make_ins(32'h006, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd4);
    issue(i, st);
    check("mis_stall", st, 0);
    @(negedge clk);
    check("mis_flag", 32'(MisalignOut), 32'd1);
    check("mis_wen", 32'(RegWrtEnOut), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_one_cycle", 32'(MisalignOut), 32'd0);
    check("mis_no_req", reqs_seen, r0);
    @(posedge clk); #1;

    // LHU at 0x010 flushed while waiting.
    set_word(32'h010, 32'h0000_F00D);
    force_delay = 1; r0 = reqs_seen;
    i = make_ins(32'h010, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1, 5'd5);
    i.flush_wait = 1'b1;
    issue(i, st);
    check("flush_req_done", reqs_seen, r0 + 1);
    @(negedge clk);
    check("flush_valid", 32'(ValidOut), 32'd0);
    check("flush_wen", 32'(RegWrtEnOut), 32'd0);
    @(posedge clk); #1;

    // Reset in WAIT, then a late ack.
    resp_en = 1'b0;
    ValidIn = 1'b1; MemReadIn = 1'b1; ALUresultIn = 32'h20; Funct3In = 3'd2;
    @(posedge clk); #1;
    ValidIn = 1'b0; MemReadIn = 1'b0;
    check("rw_req_up", 32'(dm_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rw_req_async_drop", 32'(dm_req), 32'd0);
    check("rw_stall_drop", 32'(StallOut), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dm_ack = 1'b1;
    @(negedge clk);
    check("rw_late_ack_req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("rw_late_ack_valid", 32'(ValidOut), 32'd0);
    check("rw_late_ack_idle", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    resp_en = 1'b1;

    // Random traffic.
    force_delay = -1;
    for (int n = 0; n < 300; n++) begin
      i = rand_ins();
      issue(i, st);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_wb", exp_q.size(), 0);
    check("drain_req", exp_req.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
